// File: rtl/comb_pkg.sv
// Shared constants for the combinational sweep checker: FSM encodings,
// vector/implementation counts and the default expected truth table.
package comb_pkg;

  localparam int VEC_W  = 4;
  localparam int N_VEC  = 16;
  localparam int N_IMPL = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [N_VEC-1:0] EXP_TT_DEFAULT = 16'hA5C3;

endpackage

// File: rtl/comb_settle_timer.sv
// Loadable 4-bit down-counter with a zero flag; it holds at zero until
// it is reloaded.
module comb_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/comb_sweep_checker.sv
// Sweeps {A,B,C,D} through all 16 codes, samples up to four implementations
// after SETTLE extra cycles per code, and reports the truth table and disagreement.
module comb_sweep_checker
  import comb_pkg::*;
#(
  parameter int unsigned      SETTLE    = 2,
  parameter logic [N_VEC-1:0] EXP_TT    = EXP_TT_DEFAULT,
  parameter logic [N_IMPL-1:0] IMPL_MASK = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [VEC_W-1:0]  abcd,
  input  logic [N_IMPL-1:0] y_in,
  output logic              busy,
  output logic              done,
  output logic [N_VEC-1:0]  tt0,
  output logic [N_IMPL-1:0] disagree,
  output logic              pass
);

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);

  logic [1:0]        state_q, state_d;
  logic [VEC_W-1:0]  idx_q, idx_d;
  logic [N_VEC-1:0]  tt0_q, tt0_d, tt0_smp;
  logic [N_IMPL-1:0] dis_q, dis_d, dis_smp;
  logic              pass_q, pass_d;
  logic              tmr_load, tmr_en, tmr_zero;

  comb_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (SETTLE_V),
    .zero     (tmr_zero)
  );

  always_comb begin
    tt0_smp        = tt0_q;
    tt0_smp[idx_q] = y_in[0];
    dis_smp        = dis_q;
    for (int k = 1; k < N_IMPL; k++) begin
      if (IMPL_MASK[k] && (y_in[k] != y_in[0])) dis_smp[k] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tt0_d    = tt0_q;
    dis_d    = dis_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d    = '0;
          tt0_d    = '0;
          dis_d    = '0;
          pass_d   = 1'b0;
          tmr_load = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          tt0_d = tt0_smp;
          dis_d = dis_smp;
          if (idx_q != 4'hF) begin
            idx_d    = idx_q + 4'd1;
            tmr_load = 1'b1;
          end else begin
            // Final verdict is taken on the complete table so it is valid during done.
            dis_d[0] = IMPL_MASK[0] && (tt0_smp != EXP_TT);
            pass_d   = (dis_d == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tt0_q   <= '0;
      dis_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tt0_q   <= tt0_d;
      dis_q   <= dis_d;
      pass_q  <= pass_d;
    end
  end

  assign abcd     = idx_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign tt0      = tt0_q;
  assign disagree = dis_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_comb_sweep_checker.sv
// Drives two checker instances from truth-table models of the implementations
// and compares sweep timing and results against a table-level reference.
module tb_comb_sweep_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [3:0]  abcd0, abcd1, y0, y1;
  logic        busy0, busy1, done0, done1, pass0, pass1;
  logic [15:0] tt00, tt01;
  logic [3:0]  dis0, dis1;

  logic [15:0] tt_m [4];
  logic        inj = 1'b0;
  int          sel = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  comb_sweep_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abcd(abcd0), .y_in(y0),
    .busy(busy0), .done(done0), .tt0(tt00), .disagree(dis0), .pass(pass0)
  );

  comb_sweep_checker #(.SETTLE(0), .IMPL_MASK(4'b0011)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abcd(abcd1), .y_in(y1),
    .busy(busy1), .done(done1), .tt0(tt01), .disagree(dis1), .pass(pass1)
  );

  always_comb begin
    for (int k = 0; k < 4; k++) y0[k] = tt_m[k][abcd0] ^ (inj && (k == 2) && (abcd0 == 4'h7));
    y1 = {2'b00, tt_m[1][abcd1], tt_m[0][abcd1]};
  end

  logic [3:0]  abcd_s, dis_s;
  logic        busy_s, done_s, pass_s;
  logic [15:0] tt0_s;
  always_comb begin
    abcd_s = (sel == 1) ? abcd1 : abcd0;
    busy_s = (sel == 1) ? busy1 : busy0;
    done_s = (sel == 1) ? done1 : done0;
    tt0_s  = (sel == 1) ? tt01  : tt00;
    dis_s  = (sel == 1) ? dis1  : dis0;
    pass_s = (sel == 1) ? pass1 : pass0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: evaluate every implementation over all 16 codes.
  task automatic model(input logic [3:0] mask, input bit use_inj,
                       output logic [15:0] e_tt, output logic [3:0] e_dis, output logic e_pass);
    logic [3:0] y;
    e_tt  = '0;
    e_dis = '0;
    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < 4; k++) y[k] = tt_m[k][v] ^ (use_inj && k == 2 && v == 7);
      e_tt[v] = y[0];
      for (int k = 1; k < 4; k++) if (mask[k] && y[k] != y[0]) e_dis[k] = 1'b1;
    end
    e_dis[0] = mask[0] && (e_tt != 16'hA5C3);
    e_pass   = (e_dis == 4'b0000);
  endtask

  task automatic sweep(input string tag, input int s, input int settle, input logic [3:0] mask,
                       input bit restart, input bit do_rst);
    int busy_cnt = 0, done_cnt = 0, abcd_err = 0, per, total;
    bit restarted = 0;
    logic [15:0] e_tt; logic [3:0] e_dis; logic e_pass;
    sel = s;
    per = settle + 1;
    total = 16 * per;
    model(mask, (s == 0) && inj, e_tt, e_dis, e_pass);
    @(negedge clk);
    if (s == 1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    for (int n = 1; n <= total + 6; n++) begin
      if (n > 1) @(negedge clk);
      start0 = 1'b0;
      if (busy_s) begin
        busy_cnt++;
        if (n > total || abcd_s !== 4'((n - 1) / per)) abcd_err++;
      end
      if (done_s) done_cnt++;
      if (restart && !restarted && abcd_s == 4'h5) begin
        start0 = 1'b1;
        restarted = 1;
      end
      if (do_rst && abcd_s == 4'h9) begin
        #2 rst_n = 1'b0;
        #1 chk({tag, "_rst_outs"}, {abcd_s, busy_s, done_s, tt0_s, dis_s, pass_s}, 32'h0);
        repeat (2) @(negedge clk);
        chk({tag, "_rst_hold"}, {abcd_s, busy_s, done_s, tt0_s, dis_s, pass_s}, 32'h0);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (total) begin
          @(negedge clk);
          if (done_s || busy_s) done_cnt++;
        end
        chk({tag, "_no_done"}, done_cnt, 0);
        return;
      end
    end
    chk({tag, "_busy_len"}, busy_cnt, total);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_abcd_seq"}, abcd_err, 0);
    chk({tag, "_tt0"}, tt0_s, e_tt);
    chk({tag, "_disagree"}, dis_s, e_dis);
    chk({tag, "_pass"}, pass_s, e_pass);
    chk({tag, "_abcd_end"}, abcd_s, 4'hF);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) tt_m[k] = 16'hA5C3;
    #1 chk("reset_outs", {abcd0, busy0, done0, tt00, dis0, pass0}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    sweep("t1_clean", 0, 2, 4'b1111, 0, 0);
    inj = 1'b1;
    sweep("t2_glitch", 0, 2, 4'b1111, 0, 0);
    inj = 1'b0;
    tt_m[0] = 16'hA5C2;
    sweep("t3_impl0_bad", 0, 2, 4'b1111, 0, 0);
    tt_m[0] = 16'hA5C3;
    sweep("t4_restart", 0, 2, 4'b1111, 1, 0);
    sweep("t5_reset", 0, 2, 4'b1111, 0, 1);
    sweep("t5_after", 0, 2, 4'b1111, 0, 0);
    sweep("t6_settle0", 1, 0, 4'b0011, 0, 0);

    for (int r = 0; r < 6; r++) begin
      tt_m[0] = ($urandom_range(0, 1) == 0) ? 16'hA5C3 : 16'($urandom);
      for (int k = 1; k < 4; k++)
        tt_m[k] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : tt_m[0];
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sweep($sformatf("rnd%0d_u0", r), 0, 2, 4'b1111, 0, 0);
      sweep($sformatf("rnd%0d_u1", r), 1, 0, 4'b0011, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
